// File: rtl/signal_debouncer.sv
// signal_debouncer: input conditioning for a raw asynchronous line.
// A 2-flop synchroniser feeds a counter-qualified FSM. The block outputs a
// clean level (optionally inverted), one-cycle rising/falling edge pulses and
// a busy flag. Every output comes from a flop.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   STABLE_LOW  | accepted level 0, waiting for a synchronised 1
//   QUAL_HIGH   | accepted level 0, counting consecutive 1 samples
//   STABLE_HIGH | accepted level 1, waiting for a synchronised 0
//   QUAL_LOW    | accepted level 1, counting consecutive 0 samples
module signal_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNTER_WIDTH   = 8,
    parameter int INVERT_OUTPUT   = 0
) (
    input  logic clockSignal,
    input  logic resetSignalN,
    input  logic inputSignalOne,
    input  logic enableSignal,
    output logic outputSignal,
    output logic risingPulse,
    output logic fallingPulse,
    output logic busySignal
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    // The qualifying sample that makes the count reach DEBOUNCE_CYCLES is
    // taken while the counter shows DEBOUNCE_CYCLES-1, so the counter never
    // goes beyond that value.
    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic                     INV_BIT  = (INVERT_OUTPUT != 0);

    logic                     sync1_q, sync2_q;
    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;
    logic                     busy_q, busy_d;

    // Two-flop synchroniser. It keeps running while qualification is disabled.
    always_ff @(posedge clockSignal or negedge resetSignalN) begin
        if (!resetSignalN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= inputSignalOne;
            sync2_q <= sync1_q;
        end
    end

    // State register, qualification counter and registered outputs.
    always_ff @(posedge clockSignal or negedge resetSignalN) begin
        if (!resetSignalN) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and counter logic. A disabled or broken qualification
    // falls back to the stable state it started from.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            STABLE_LOW: begin
                if (enableSignal && sync2_q) begin
                    state_d = QUAL_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_HIGH: begin
                if (!enableSignal || !sync2_q) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (enableSignal && !sync2_q) begin
                    state_d = QUAL_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_LOW: begin
                if (!enableSignal || sync2_q) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
            end
        endcase
    end

    // Output decode. It is computed from the next state so that the
    // registered outputs change on the same edge as the state.
    always_comb begin
        rise_d  = (state_q == QUAL_HIGH) && (state_d == STABLE_HIGH);
        fall_d  = (state_q == QUAL_LOW)  && (state_d == STABLE_LOW);
        busy_d  = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
        level_d = (state_d == STABLE_HIGH) || (state_d == QUAL_LOW);
    end

    assign outputSignal = level_q ^ INV_BIT;
    assign risingPulse  = rise_q;
    assign fallingPulse = fall_q;
    assign busySignal   = busy_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// Testbench for signal_debouncer. It runs two instances side by side, one
// plain and one inverting, with DEBOUNCE_CYCLES=4. A run-length reference
// model checks every cycle, and some steps also check fixed edge timings.
module tb_signal_debouncer;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_in;
    logic en_in;
    logic out0, rise0, fall0, busy0;
    logic out1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    // Reference model: a two-sample delay line, the accepted level, and the
    // length of the current run of enabled samples that differ from it.
    logic m_s1, m_s2, m_level, m_rise, m_fall;
    int   m_run;

    int pulse_cnt;
    int hold;
    logic cur;

    always #5 clk = ~clk;

    signal_debouncer #(.DEBOUNCE_CYCLES(DEB), .COUNTER_WIDTH(8), .INVERT_OUTPUT(0)) dut0 (
        .clockSignal(clk), .resetSignalN(rst_n), .inputSignalOne(raw_in), .enableSignal(en_in),
        .outputSignal(out0), .risingPulse(rise0), .fallingPulse(fall0), .busySignal(busy0));

    signal_debouncer #(.DEBOUNCE_CYCLES(DEB), .COUNTER_WIDTH(8), .INVERT_OUTPUT(1)) dut1 (
        .clockSignal(clk), .resetSignalN(rst_n), .inputSignalOne(raw_in), .enableSignal(en_in),
        .outputSignal(out1), .risingPulse(rise1), .fallingPulse(fall1), .busySignal(busy1));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input logic raw, input logic en);
        logic s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!en || s == m_level) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DEB) begin
                m_level = s;
                m_rise  = s;
                m_fall  = !s;
                m_run   = 0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":out"},     out0,  m_level);
        chk({ctx, ":out_inv"}, out1,  ~m_level);
        chk({ctx, ":rise"},    rise0, m_rise);
        chk({ctx, ":fall"},    fall0, m_fall);
        chk({ctx, ":busy"},    busy0, (m_run > 0));
        chk({ctx, ":inv_pulses"}, {rise1, fall1, busy1} == {rise0, fall0, busy0}, 1'b1);
    endtask

    task automatic step(input logic raw, input logic en, input string ctx);
        raw_in = raw;
        en_in  = en;
        @(posedge clk);
        model_edge(raw, en);
        #1;
        check_all(ctx);
        if (rise0) pulse_cnt++;
    endtask

    // Asserts reset in mid-cycle, checks outputs before any edge, holds
    // reset across one edge, then releases it away from the edge.
    task automatic async_reset(input string ctx);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all({ctx, ":async"});
        @(posedge clk);
        #1;
        check_all({ctx, ":held"});
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [8:0] bounce;
        rst_n = 1'b0;
        raw_in = 1'b1;
        en_in = 1'b1;
        pulse_cnt = 0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_edge");
        #2 rst_n = 1'b1;

        // Release with the raw line already high: rise on the 6th edge.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, "rel");
            chk("rel_rise_edge6", rise0, (i == 6));
        end

        // Clean fall, then clean rise, with fixed timing.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, "fall");
            chk("fall_edge6", fall0, (i == 6));
            chk("fall_busy_3to5", busy0, (i >= 3 && i <= 5));
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, "rise");
            chk("rise_edge6", rise0, (i == 6));
            chk("rise_busy_3to5", busy0, (i >= 3 && i <= 5));
            chk("rise_level", out0, (i >= 6));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "to_low");

        // Glitch of 3 samples must be ignored.
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "glitch");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "glitch");
        chk("glitch_no_pulse", (pulse_cnt == 0), 1'b1);
        chk("glitch_level", out0, 1'b0);
        chk("glitch_busy", busy0, 1'b0);

        // Bounce then settle: a single rise, 4 samples after the last 0.
        bounce = 9'b1_1110_1101;
        pulse_cnt = 0;
        for (int i = 1; i <= 13; i++) begin
            step((i <= 9) ? bounce[i-1] : 1'b1, 1'b1, "bounce");
            chk("bounce_rise_edge11", rise0, (i == 11));
        end
        chk("bounce_single_pulse", (pulse_cnt == 1), 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "to_low2");

        // Disable at counter=2, then re-enable: qualification restarts.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, (i != 5), "enable");
            if (i == 5) chk("en_off_busy", busy0, 1'b0);
            chk("en_rise_edge9", rise0, (i == 9));
        end

        // Async reset in the middle of QUAL_LOW.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "qual_low");
        chk("qual_low_busy", busy0, 1'b1);
        chk("qual_low_inv_out", out1, 1'b0);
        async_reset("midqual");
        chk("midqual_inv_out", out1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, "inv");
            chk("inv_level", out1, !(i >= 6));
        end

        // Randomised run lengths, occasional disable, rare resets.
        cur = 1'b0;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                cur  = ~cur;
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
            step(cur, ($urandom_range(0, 11) != 0), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
